bridge_1xn: RTL and testbench

Parametrised successor to the two-way data-side bridge: routes the CPU's single SRAM-style data port to `NSLV` slave windows by parametrised base/mask address decode. It tracks the one-cycle slave read latency so read data returns from the slave that was addressed. Unmapped accesses go to an internal default slave that returns a fixed word and logs the miss. It sits between `cpu_pipeline`'s `cpu_data_*` port and the data SRAM, confreg and future peripherals in the SoC top.

---
 rtl/bridge_1xn.sv | 120 ++++++++++++
 tb/tb_bridge_1xn.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_1xn.sv
// One-master to NSLV-slave data-side bridge with base/mask address decode,
// one-cycle read-return tracking, and a default slave that logs unmapped accesses.
module bridge_1xn #(
  parameter int unsigned NSLV = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter logic [DW-1:0] MISS_RDATA = DW'(32'hDEAD_BEEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_data_en,
  input  logic [DW/8-1:0]        cpu_data_wen,
  input  logic [AW-1:0]          cpu_data_addr,
  input  logic [DW-1:0]          cpu_data_wdata,
  output logic [DW-1:0]          cpu_data_rdata,
  output logic [NSLV-1:0]        slv_en,
  output logic [NSLV*DW/8-1:0]   slv_wen,
  output logic [NSLV*AW-1:0]     slv_addr,
  output logic [NSLV*DW-1:0]     slv_wdata,
  input  logic [NSLV*DW-1:0]     slv_rdata,
  output logic [15:0]            miss_cnt,
  output logic [AW-1:0]          miss_addr
);

  localparam int unsigned BW = DW / 8;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [NSLV-1:0] hit;
  logic [NSLV-1:0] sel;
  logic            miss;
  logic            taken;

  logic [NSLV-1:0] sel_q;
  logic            miss_q;
  logic            rd_q;
  logic [DW-1:0]   hold_q;
  logic [DW-1:0]   slv_sel_data;
  logic [DW-1:0]   ret_data;
  logic            rd_req;
  logic            miss_req;

  // Window decode; lowest index wins when windows overlap.
  always_comb begin
    hit   = '0;
    sel   = '0;
    taken = 1'b0;
    for (int i = 0; i < int'(NSLV); i++) begin
      hit[i] = ((cpu_data_addr & SLV_MASK[AW*i +: AW]) ==
                (SLV_BASE[AW*i +: AW] & SLV_MASK[AW*i +: AW]));
      if (hit[i] && !taken) begin
        sel[i] = 1'b1;
        taken  = 1'b1;
      end
    end
    miss = ~|hit;
  end

  assign rd_req   = cpu_data_en & ~|cpu_data_wen;
  assign miss_req = cpu_data_en & miss;

  // Request phase: enables and byte enables only reach the selected slave.
  always_comb begin
    slv_en  = '0;
    slv_wen = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      slv_en[i] = cpu_data_en & sel[i];
      if (sel[i]) begin
        slv_wen[BW*i +: BW] = cpu_data_wen;
      end
    end
  end

  assign slv_addr  = {NSLV{cpu_data_addr}};
  assign slv_wdata = {NSLV{cpu_data_wdata}};

  // Response mux: sel_q is one-hot or zero, so an OR-reduction suffices.
  always_comb begin
    slv_sel_data = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_q[i]) begin
        slv_sel_data = slv_sel_data | slv_rdata[DW*i +: DW];
      end
    end
    ret_data       = miss_q ? MISS_RDATA : slv_sel_data;
    cpu_data_rdata = rd_q ? ret_data : hold_q;
  end

  // Response tracking and read-data hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q  <= '0;
      miss_q <= 1'b0;
      rd_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      sel_q  <= cpu_data_en ? sel : '0;
      miss_q <= miss_req;
      rd_q   <= rd_req;
      if (rd_q) begin
        hold_q <= ret_data;
      end
    end
  end

  // Miss log: saturating counter plus last unmapped address.
  always_ff @(posedge clk) begin
    if (reset) begin
      miss_cnt  <= '0;
      miss_addr <= '0;
    end else if (miss_req) begin
      if (miss_cnt != CNT_MAX) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
      miss_addr <= cpu_data_addr;
    end
  end

endmodule

// File: tb/tb_bridge_1xn.sv
// Directed bench for bridge_1xn: transaction-level model checked every cycle,
// plus literal expectations from the hand-worked scenarios.
module tb_bridge_1xn;

  localparam int unsigned NSLV = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] MISS = 32'hDEAD_BEEF;

  // Windows: 0 low 64K, 1 confreg page, 2 narrow at 0x200xxxxx, 3 wide 0x2xxxxxxx (overlaps 2)
  localparam logic [31:0] BASE [NSLV] = '{32'h0000_0000, 32'hBFAF_0000, 32'h2000_0000, 32'h2000_0000};
  localparam logic [31:0] MASK [NSLV] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF0_0000, 32'hF000_0000};

  logic                 clk;
  logic                 reset;
  logic                 cpu_data_en;
  logic [3:0]           cpu_data_wen;
  logic [31:0]          cpu_data_addr;
  logic [31:0]          cpu_data_wdata;
  logic [31:0]          cpu_data_rdata;
  logic [NSLV-1:0]      slv_en;
  logic [NSLV*4-1:0]    slv_wen;
  logic [NSLV*32-1:0]   slv_addr;
  logic [NSLV*32-1:0]   slv_wdata;
  logic [NSLV*32-1:0]   slv_rdata;
  logic [15:0]          miss_cnt;
  logic [31:0]          miss_addr;
  logic [31:0]          rdv [NSLV];

  int n_tests = 0;
  int n_fail  = 0;

  bridge_1xn #(
    .NSLV(NSLV), .AW(AW), .DW(DW),
    .SLV_BASE({BASE[3], BASE[2], BASE[1], BASE[0]}),
    .SLV_MASK({MASK[3], MASK[2], MASK[1], MASK[0]}),
    .MISS_RDATA(MISS)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_data_en(cpu_data_en), .cpu_data_wen(cpu_data_wen),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
    .cpu_data_rdata(cpu_data_rdata),
    .slv_en(slv_en), .slv_wen(slv_wen), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .miss_cnt(miss_cnt), .miss_addr(miss_addr)
  );

  always_comb begin
    for (int i = 0; i < int'(NSLV); i++) slv_rdata[32*i +: 32] = rdv[i];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < int'(NSLV); i++)
      if ((a & MASK[i]) == (BASE[i] & MASK[i])) return i;
    return -1;
  endfunction

  // Transaction model: what the previous request owes the master this cycle.
  logic        armed = 1'b0;
  logic        m_rd = 1'b0;
  int          m_idx = -1;
  logic [31:0] m_hold = '0;
  logic [15:0] m_cnt = '0;
  logic [31:0] m_maddr = '0;

  function automatic logic [31:0] model_rdata();
    if (!m_rd) return m_hold;
    if (m_idx < 0) return MISS;
    return rdv[m_idx];
  endfunction

  always @(posedge clk) begin
    int idx;
    idx = dec(cpu_data_addr);
    if (reset) begin
      armed = 1'b1;
      m_rd = 1'b0; m_idx = -1; m_hold = '0; m_cnt = '0; m_maddr = '0;
    end else begin
      if (m_rd) m_hold = model_rdata();
      m_rd  = cpu_data_en && (cpu_data_wen == 4'h0);
      m_idx = idx;
      if (cpu_data_en && idx < 0) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_maddr = cpu_data_addr;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (armed) begin
      int idx;
      logic [NSLV-1:0]   e_en;
      logic [NSLV*4-1:0] e_wen;
      idx = dec(cpu_data_addr);
      e_en = '0; e_wen = '0;
      if (idx >= 0) begin
        e_en[idx] = cpu_data_en;
        e_wen[4*idx +: 4] = cpu_data_wen;
      end
      chk("rdata", 64'(cpu_data_rdata), 64'(model_rdata()));
      chk("slv_en", 64'(slv_en), 64'(e_en));
      chk("slv_wen", 64'(slv_wen), 64'(e_wen));
      chk("slv_addr", 64'(slv_addr[32*(NSLV-1) +: 32]), 64'(cpu_data_addr));
      chk("slv_wdata", 64'(slv_wdata[32*(NSLV-1) +: 32]), 64'(cpu_data_wdata));
      chk("miss_cnt", 64'(miss_cnt), 64'(m_cnt));
      chk("miss_addr", 64'(miss_addr), 64'(m_maddr));
    end
  end

  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    cpu_data_en = en; cpu_data_wen = wen; cpu_data_addr = addr; cpu_data_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < int'(NSLV); i++) rdv[i] = 32'h0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset rdata", 64'(cpu_data_rdata), 64'h0);
    chk("reset miss_cnt", 64'(miss_cnt), 64'h0);
    chk("reset miss_addr", 64'(miss_addr), 64'h0);
    tick();

    // Write to slave0
    drive(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
    @(negedge clk);
    chk("wr slv_en", 64'(slv_en), 64'b0001);
    chk("wr slv_wen", 64'(slv_wen), 64'h000F);
    tick();

    // Read slave1, data returned next cycle
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    @(negedge clk);
    chk("rd1 slv_en", 64'(slv_en), 64'b0010);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    rdv[1] = 32'hCAFE_0001; rdv[0] = 32'h0BAD_0000;
    @(negedge clk);
    chk("rd1 rdata", 64'(cpu_data_rdata), 64'hCAFE_0001);
    tick();

    // Back-to-back reads s0 then s1
    drive(1'b1, 4'h0, 32'h0000_0000, 32'h0);
    tick();
    drive(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    rdv[0] = 32'hAA; rdv[1] = 32'h0;
    @(negedge clk);
    chk("b2b first", 64'(cpu_data_rdata), 64'hAA);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    rdv[0] = 32'h0; rdv[1] = 32'hBB;
    @(negedge clk);
    chk("b2b second", 64'(cpu_data_rdata), 64'hBB);
    tick();

    // Unmapped read
    drive(1'b1, 4'h0, 32'h8000_0000, 32'h0);
    @(negedge clk);
    chk("miss slv_en", 64'(slv_en), 64'h0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("miss rdata", 64'(cpu_data_rdata), 64'hDEAD_BEEF);
    chk("miss cnt1", 64'(miss_cnt), 64'h1);
    chk("miss addr1", 64'(miss_addr), 64'h8000_0000);
    tick();

    // Hold across idle and write cycles
    drive(1'b1, 4'h0, 32'h0000_0004, 32'h0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    rdv[0] = 32'h55;
    @(negedge clk);
    chk("hold read", 64'(cpu_data_rdata), 64'h55);
    tick();
    rdv[0] = 32'h77;
    drive(1'b1, 4'h3, 32'h0000_0004, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("hold idle", 64'(cpu_data_rdata), 64'h55);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    rdv[0] = 32'h99;
    @(negedge clk);
    chk("hold after write", 64'(cpu_data_rdata), 64'h55);
    tick();

    // Overlapping windows: lowest index wins
    drive(1'b1, 4'h0, 32'h0000_1000, 32'h0);
    @(negedge clk);
    chk("ovl 0x1000", 64'(slv_en), 64'b0001);
    tick();
    drive(1'b1, 4'h0, 32'h2000_0040, 32'h0);
    @(negedge clk);
    chk("ovl s2 over s3", 64'(slv_en), 64'b0100);
    tick();
    drive(1'b1, 4'h5, 32'h2010_0000, 32'h0);
    @(negedge clk);
    chk("s3 only", 64'(slv_en), 64'b1000);
    chk("s3 wen", 64'(slv_wen), 64'h5000);
    tick();

    // Write miss is dropped but logged
    drive(1'b1, 4'hF, 32'h9000_0000, 32'h1);
    @(negedge clk);
    chk("wmiss slv_en", 64'(slv_en), 64'h0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wmiss cnt", 64'(miss_cnt), 64'h2);
    chk("wmiss addr", 64'(miss_addr), 64'h9000_0000);
    tick();

    // Saturation: fill to FFFE, then three more misses
    while (m_cnt != 16'hFFFE) begin
      drive(1'b1, 4'hF, 32'h8000_0000 | 32'(m_cnt), 32'h0);
      tick();
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("sat FFFE", 64'(miss_cnt), 64'hFFFE);
    tick();
    drive(1'b1, 4'h0, 32'hC000_0001, 32'h0); tick();
    drive(1'b1, 4'hF, 32'hC000_0002, 32'h0); tick();
    drive(1'b1, 4'h0, 32'hC000_0003, 32'h0); tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("sat FFFF", 64'(miss_cnt), 64'hFFFF);
    chk("sat addr", 64'(miss_addr), 64'hC000_0003);
    tick();

    // Reset with a read response pending
    drive(1'b1, 4'h0, 32'h0000_0008, 32'h0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    rdv[0] = 32'h1234_ABCD;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst pend rdata", 64'(cpu_data_rdata), 64'h0);
    chk("rst miss_cnt", 64'(miss_cnt), 64'h0);
    chk("rst miss_addr", 64'(miss_addr), 64'h0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
